// File: rtl/reg_writeback_ctrl.sv
// Write-back sequencer for the register bank: queues address/data requests and
// replays them as a one-hot select plus data, with a pending-write scoreboard.
module reg_writeback_ctrl #(
  parameter int DATA_W     = 32,
  parameter int NREG       = 16,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_flush,
  output logic [NREG-1:0]   register,
  output logic [DATA_W-1:0] din,
  output logic [NREG-1:0]   pending,
  output logic              busy,
  output logic              err_addr
);

  // state  | meaning
  // IDLE   | no write in flight; waits for a queued request
  // SETUP  | din loaded with the in-flight entry, select still 0
  // STROBE | one-hot select asserted for exactly one cycle

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      count;
  logic [ADDR_W-1:0]   cur_addr;
  logic                full, has_entry, push, pop, err_set, addr_ok;
  logic [NREG-1:0]     register_nxt;
  logic [DATA_W-1:0]   din_nxt;

  assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign wb_ready  = rst_n & ~full & ~wb_flush;
  assign push      = wb_valid & wb_ready;
  // a flushing cycle must not hand a doomed entry to the sequencer
  assign has_entry = (count != '0) & ~wb_flush;
  assign busy      = (count != '0) | (state != IDLE);
  assign addr_ok   = ({1'b0, cur_addr} < (ADDR_W+1)'(NREG));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wb_addr;
      fifo_data[wr_ptr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (wb_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    register_nxt = '0;
    din_nxt      = din;
    pop          = 1'b0;
    err_set      = 1'b0;
    case (state)
      IDLE, STROBE: begin
        state_nxt = IDLE;
        if (has_entry) begin
          pop       = 1'b1;
          din_nxt   = fifo_data[rd_ptr];
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (wb_flush) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = STROBE;
          if (addr_ok) begin
            for (int j = 0; j < NREG; j++)
              if (cur_addr == ADDR_W'(j)) register_nxt[j] = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      register <= '0;
      din      <= '0;
      err_addr <= 1'b0;
      cur_addr <= '0;
    end else begin
      state    <= state_nxt;
      register <= register_nxt;
      din      <= din_nxt;
      if (err_set) err_addr <= 1'b1;
      if (pop)     cur_addr <= fifo_addr[rd_ptr];
    end
  end

  // live FIFO slots are those within count entries of the read pointer
  always_comb begin
    pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < count) begin
        for (int j = 0; j < NREG; j++)
          if (fifo_addr[i] == ADDR_W'(j)) pending[j] = 1'b1;
      end
    end
    if (state != IDLE) begin
      for (int j = 0; j < NREG; j++)
        if (cur_addr == ADDR_W'(j)) pending[j] = 1'b1;
    end
  end

endmodule
